// File: rtl/bayer_demosaic_stream.sv
// Streaming Bayer-to-RGB converter: 2x2 window from a one-line buffer plus column history,
// any of the four Bayer phases, colour or luma output, tolerant of gapped valid.
module bayer_demosaic_stream #(
  parameter int unsigned DW         = 12,
  parameter int unsigned LINE_WIDTH = 1280,
  parameter int unsigned XW         = 11,
  parameter int unsigned YW         = 11
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [XW-1:0] iX_Cont,
  input  logic [YW-1:0] iY_Cont,
  input  logic [DW-1:0] iDATA,
  input  logic          iDVAL,
  input  logic [1:0]    iPATTERN,
  input  logic          iGRAY,
  output logic [DW-1:0] oRed,
  output logic [DW-1:0] oGreen,
  output logic [DW-1:0] oBlue,
  output logic          oDVAL,
  output logic [XW-1:0] oX_Cont,
  output logic [YW-1:0] oY_Cont,
  output logic          oOVF
);

  localparam int unsigned AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int unsigned GW = DW + 1;
  localparam int unsigned SW = DW + 2;

  logic [DW-1:0] line_mem [LINE_WIDTH];

  logic          accept_c, frame_start_c;
  logic [AW-1:0] addr_c;

  logic [DW-1:0] up_q, cur_q, cur_d, up_prev_q, up_prev_d, cur_prev_q, cur_prev_d;
  logic          pend_q, pend_d, col_q, col_d, row_q, row_d, gray1_q, gray1_d;
  logic [XW-1:0] x1_q, x1_d;
  logic [YW-1:0] y1_q, y1_d;
  logic [1:0]    pat_q, pat_d;
  logic          gray_q, gray_d, armed_q, armed_d, ovf_q, ovf_d;
  logic [DW-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic          dval_q, dval_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;

  logic [DW-1:0] r_pix_c, b_pix_c, g1_pix_c, g2_pix_c;
  logic [GW-1:0] g_sum_c;
  logic [SW-1:0] y_sum_c;

  assign addr_c        = AW'(iX_Cont);
  assign accept_c      = iDVAL && (32'(iX_Cont) < 32'(LINE_WIDTH));
  assign frame_start_c = accept_c && (iX_Cont == '0) && (iY_Cont == '0);

  // Line buffer: read-before-write at the beat column; contents survive reset.
  always_ff @(posedge iCLK) begin
    if (!iRST && accept_c) line_mem[addr_c] <= iDATA;
  end

  always_ff @(posedge iCLK) begin
    if (iRST)          up_q <= '0;
    else if (accept_c) up_q <= line_mem[addr_c];
  end

  // Window is [top,bottom]x[left,right] = {up_prev,up}/{cur_prev,cur}; row/col are the
  // parity of the bottom-right pixel after pattern flip, which places R, B and the two Gs.
  always_comb begin
    r_pix_c  = row_q ? (col_q ? up_prev_q : up_q)      : (col_q ? cur_prev_q : cur_q);
    b_pix_c  = row_q ? (col_q ? cur_q     : cur_prev_q) : (col_q ? up_q       : up_prev_q);
    g1_pix_c = row_q ? (col_q ? up_q      : up_prev_q)  : (col_q ? cur_q      : cur_prev_q);
    g2_pix_c = row_q ? (col_q ? cur_prev_q : cur_q)     : (col_q ? up_prev_q  : up_q);
    g_sum_c  = GW'(g1_pix_c) + GW'(g2_pix_c);
    y_sum_c  = SW'(r_pix_c) + SW'(g1_pix_c) + SW'(g2_pix_c) + SW'(b_pix_c);
  end

  always_comb begin
    cur_d      = cur_q;
    cur_prev_d = cur_prev_q;
    up_prev_d  = up_prev_q;
    pend_d     = 1'b0;
    col_d      = col_q;
    row_d      = row_q;
    gray1_d    = gray1_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    pat_d      = pat_q;
    gray_d     = gray_q;
    armed_d    = armed_q;
    ovf_d      = ovf_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    dval_d     = pend_q;
    ox_d       = ox_q;
    oy_d       = oy_q;

    if (frame_start_c) begin
      pat_d  = iPATTERN;
      gray_d = iGRAY;
    end

    // Window stage: shift history and decide whether this beat emits.
    if (accept_c) begin
      if (iX_Cont == '0) armed_d = 1'b1;
      cur_d      = iDATA;
      cur_prev_d = cur_q;
      up_prev_d  = up_q;
      pend_d     = armed_q && (iX_Cont != '0) && (iY_Cont != '0);
      col_d      = iX_Cont[0] ^ pat_d[0];
      row_d      = iY_Cont[0] ^ pat_d[1];
      gray1_d    = gray_d;
      x1_d       = iX_Cont;
      y1_d       = iY_Cont;
    end

    if (iDVAL && !accept_c) ovf_d = 1'b1;

    // Output stage: colour or luma from the window captured on the previous beat.
    if (pend_q) begin
      ox_d = x1_q;
      oy_d = y1_q;
      if (gray1_q) begin
        red_d   = y_sum_c[DW+1:2];
        green_d = y_sum_c[DW+1:2];
        blue_d  = y_sum_c[DW+1:2];
      end else begin
        red_d   = r_pix_c;
        green_d = g_sum_c[DW:1];
        blue_d  = b_pix_c;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cur_q      <= '0;
      cur_prev_q <= '0;
      up_prev_q  <= '0;
      pend_q     <= 1'b0;
      col_q      <= 1'b0;
      row_q      <= 1'b0;
      gray1_q    <= 1'b0;
      x1_q       <= '0;
      y1_q       <= '0;
      pat_q      <= 2'd0;
      gray_q     <= 1'b0;
      armed_q    <= 1'b0;
      ovf_q      <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      dval_q     <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
    end else begin
      cur_q      <= cur_d;
      cur_prev_q <= cur_prev_d;
      up_prev_q  <= up_prev_d;
      pend_q     <= pend_d;
      col_q      <= col_d;
      row_q      <= row_d;
      gray1_q    <= gray1_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      pat_q      <= pat_d;
      gray_q     <= gray_d;
      armed_q    <= armed_d;
      ovf_q      <= ovf_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      dval_q     <= dval_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
    end
  end

  assign oRed    = red_q;
  assign oGreen  = green_q;
  assign oBlue   = blue_q;
  assign oDVAL   = dval_q;
  assign oX_Cont = ox_q;
  assign oY_Cont = oy_q;
  assign oOVF    = ovf_q;

endmodule

// File: tb/tb_bayer_demosaic_stream.sv
// Scoreboard bench for bayer_demosaic_stream: a coordinate-based Bayer model predicts each
// emitted pixel and its cycle; a negedge monitor pops and compares.
module tb_bayer_demosaic_stream;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        iRST = 1'b1;
  logic [10:0] iX_Cont = '0;
  logic [10:0] iY_Cont = '0;
  logic [11:0] iDATA = '0;
  logic        iDVAL = 1'b0;
  logic [1:0]  iPATTERN = '0;
  logic        iGRAY = 1'b0;
  logic [11:0] oRed, oGreen, oBlue;
  logic        oDVAL, oOVF;
  logic [10:0] oX_Cont, oY_Cont;

  bayer_demosaic_stream #(.DW(12), .LINE_WIDTH(LW), .XW(11), .YW(11)) dut (
    .iCLK(clk), .iRST(iRST), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iDATA(iDATA),
    .iDVAL(iDVAL), .iPATTERN(iPATTERN), .iGRAY(iGRAY), .oRed(oRed), .oGreen(oGreen),
    .oBlue(oBlue), .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oOVF(oOVF)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint r, g, b, x, y, cyc;
  } exp_t;

  exp_t   sb[$];
  int     tests = 0;
  int     fails = 0;
  int     pulses = 0;
  longint cyc = 0;
  longint c11[3];
  longint c21[3];
  longint last_r = 0, last_g = 0, last_b = 0, last_x = 0, last_y = 0;

  // Reference state: line contents by column and the row above it, plus frame control.
  int     lb[LW];
  int     above[LW];
  bit     m_armed = 0;
  bit     m_ovf = 0;
  bit     m_gray = 0;
  int     m_pat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t model_pixel(input int x, input int y);
    exp_t e;
    int r = 0, b = 0, gs = 0;
    for (int dy = 0; dy < 2; dy++) begin
      for (int dx = 0; dx < 2; dx++) begin
        int px = x - 1 + dx;
        int py = y - 1 + dy;
        int v  = dy ? lb[px] : above[px];
        int ph = (((py & 1) ^ ((m_pat >> 1) & 1)) * 2) + ((px & 1) ^ (m_pat & 1));
        if (ph == 0) r = v;
        else if (ph == 3) b = v;
        else gs += v;
      end
    end
    if (m_gray) begin
      e.r = (r + gs + b) / 4; e.g = e.r; e.b = e.r;
    end else begin
      e.r = r; e.g = gs / 2; e.b = b;
    end
    e.x = x; e.y = y;
    return e;
  endfunction

  task automatic beat(input int x, input int y, input int d, input bit v, input bit rst,
                      input int pat, input bit gr);
    exp_t e;
    @(negedge clk);
    iX_Cont = 11'(x); iY_Cont = 11'(y); iDATA = 12'(d); iDVAL = v; iRST = rst;
    iPATTERN = 2'(pat); iGRAY = gr;
    if (rst) begin
      m_armed = 0; m_pat = 0; m_gray = 0; m_ovf = 0;
    end else if (v) begin
      if (x >= LW) m_ovf = 1;
      else begin
        if (x == 0 && y == 0) begin m_pat = pat; m_gray = gr; end
        if (x == 0) m_armed = 1;
        above[x] = lb[x];
        lb[x] = d;
        if (m_armed && x >= 1 && y >= 1) begin
          e = model_pixel(x, y);
          e.cyc = cyc + 2;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic idle();
    beat(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
    idle();
    chk({nm, "_drain"}, sb.size(), 0);
    chk({nm, "_hold_r"}, oRed, last_r);
    chk({nm, "_hold_y"}, oY_Cont, last_y);
  endtask

  // dmode: 0 raster counter from 1, 1 all-ones, 2 random; gmode: 0 none, 1 alternate, 2 random.
  task automatic frame(input string nm, input int w, input int h, input int pat, input bit gr,
                       input int dmode, input int gmode);
    int n = 0;
    int p0 = pulses;
    for (int k = 0; k < 3; k++) begin c11[k] = -1; c21[k] = -1; end
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        int d = (dmode == 0) ? n + 1 : (dmode == 1) ? 'hFFF : int'($urandom_range(0, 4095));
        bit st = (x == 0 && y == 0);
        n++;
        beat(x, y, d, 1, 0, st ? pat : int'($urandom_range(0, 3)),
             st ? gr : 1'($urandom));
        if (gmode == 1 || (gmode == 2 && $urandom_range(0, 2) == 0)) idle();
      end
    end
    drain(nm);
    chk({nm, "_pulses"}, pulses - p0, (w - 1) * (h - 1));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (oDVAL === 1'b1) begin
      pulses++;
      if (oX_Cont == 1 && oY_Cont == 1) begin c11[0] = oRed; c11[1] = oGreen; c11[2] = oBlue; end
      if (oX_Cont == 2 && oY_Cont == 1) begin c21[0] = oRed; c21[1] = oGreen; c21[2] = oBlue; end
      if (sb.size() == 0) begin
        chk("unexpected_dval", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_x", oX_Cont, e.x);
        chk("out_y", oY_Cont, e.y);
        chk("out_red", oRed, e.r);
        chk("out_green", oGreen, e.g);
        chk("out_blue", oBlue, e.b);
        chk("out_cycle", cyc, e.cyc);
        last_r = e.r; last_g = e.g; last_b = e.b; last_x = e.x; last_y = e.y;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int p0;
    for (int i = 0; i < LW; i++) begin lb[i] = 0; above[i] = 0; end
    beat(0, 0, 0, 1, 1, 0, 0);
    beat(3, 2, 7, 1, 1, 0, 0);
    idle();
    chk("rst_dval", oDVAL, 0);
    chk("rst_red", oRed, 0);
    chk("rst_green", oGreen, 0);
    chk("rst_blue", oBlue, 0);
    chk("rst_x", oX_Cont, 0);
    chk("rst_y", oY_Cont, 0);
    chk("rst_ovf", oOVF, 0);

    frame("rggb", 8, 6, 0, 0, 0, 1);
    chk("rggb_11_r", c11[0], 'h001); chk("rggb_11_g", c11[1], 'h005); chk("rggb_11_b", c11[2], 'h00A);
    chk("rggb_21_r", c21[0], 'h003); chk("rggb_21_g", c21[1], 'h006); chk("rggb_21_b", c21[2], 'h00A);

    frame("grey", 8, 6, 0, 1, 0, 1);
    chk("grey_11_r", c11[0], 'h005); chk("grey_11_g", c11[1], 'h005); chk("grey_11_b", c11[2], 'h005);

    frame("bggr", 8, 6, 3, 0, 0, 1);
    chk("bggr_11_r", c11[0], 'h00A); chk("bggr_11_g", c11[1], 'h005); chk("bggr_11_b", c11[2], 'h001);

    frame("b2b", 8, 6, 0, 0, 0, 0);
    frame("ones_col", 8, 6, 2, 0, 1, 0);
    chk("ones_col_11_g", c11[1], 'hFFF);
    frame("ones_grey", 8, 6, 1, 1, 1, 2);
    chk("ones_grey_11_r", c11[0], 'hFFF);

    for (int i = 0; i < 8; i++)
      frame("rand", int'($urandom_range(2, 8)), int'($urandom_range(2, 6)),
            int'($urandom_range(0, 3)), 1'($urandom), 2, 2);

    // Overflow and mid-row reset, starting a GRBG frame so reset must restore RGGB.
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 8; x++) begin
        beat(x, y, int'($urandom_range(0, 4095)), 1, 0, (x == 0 && y == 0) ? 1 : 0, 0);
        idle();
      end
    beat(8, 1, 'h123, 1, 0, 0, 0);
    idle();
    chk("ovf_set", oOVF, m_ovf);
    chk("ovf_set_const", oOVF, 1);
    for (int x = 0; x < 4; x++) begin
      beat(x, 2, int'($urandom_range(0, 4095)), 1, 0, 0, 0);
      idle();
    end
    idle();
    chk("ovf_held", oOVF, 1);
    beat(4, 2, 'h777, 1, 1, 0, 0);
    @(posedge clk); #1;
    chk("midrst_dval", oDVAL, 0);
    chk("midrst_red", oRed, 0);
    chk("midrst_x", oX_Cont, 0);
    chk("midrst_ovf", oOVF, 0);
    last_r = 0; last_g = 0; last_b = 0; last_x = 0; last_y = 0;
    p0 = pulses;
    for (int x = 5; x < 8; x++) begin
      beat(x, 2, int'($urandom_range(0, 4095)), 1, 0, 0, 0);
      idle();
    end
    idle(); idle();
    chk("unarmed_silent", pulses - p0, 0);
    p0 = pulses;
    for (int y = 3; y < 5; y++)
      for (int x = 0; x < 8; x++) begin
        d = int'($urandom_range(0, 4095));
        beat(x, y, d, 1, 0, int'($urandom_range(0, 3)), 1'($urandom));
      end
    drain("resume");
    chk("resume_pulses", pulses - p0, 14);
    chk("resume_ovf", oOVF, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
